multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 valid  input  1  the E-stage instruction is a multi-cycle M-extension op.
REQ-004 op  input  mdu_op_t (4)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
REQ-005 a, b  input  64 each  forwarded source operands from E.
REQ-006 stall  input  1  E stage held by a downstream wait (stallE with e_wait low).
REQ-007 flush  input  1  E-stage flush, e.g. an mret in writeback.
REQ-008 e_wait  output  1  result not ready; consumed by the hazard unit as its E-stage wait.
REQ-009 result  output  64  final result, valid while e_wait is low and state is DONE.

Function
REQ-010 Three states SHALL exist: IDLE, BUSY and DONE.
REQ-011 IDLE with valid=1 and flush=0 SHALL latch op and operands, transition to BUSY, and drive e_wait=1 combinationally in that same cycle.
REQ-012 e_wait SHALL be 1 in IDLE with valid=1, and 1 throughout BUSY, which is (valid&&IDLE)||BUSY.
REQ-013 e_wait SHALL be 0 in DONE and 0 in IDLE with valid=0.
REQ-014 Multiplies SHALL use radix-2 shift-add over unsigned magnitudes, with the sign applied at the end.
REQ-015 Divides SHALL use restoring division over unsigned magnitudes: quotient sign = sa^sb, remainder sign = sign of the dividend.
REQ-016 Iteration count SHALL be 64 for 64-bit ops and 32 for W ops, with one bit per cycle held in a 7-bit counter.
REQ-017 From valid to e_wait falling SHALL take N+1 cycles, where N is the iteration count.
REQ-018 MULH/MULHSU/MULHU SHALL return product[127:64]; MUL SHALL return product[63:0].
REQ-019 W ops SHALL operate on a[31:0] and b[31:0] (sign- or zero-extended per op) and sign-extend result bit 31 to 64 bits.
REQ-020 Divide by zero SHALL skip iteration and go to DONE after one BUSY cycle, with these results:
- quotient = all ones;
- remainder = the dividend (W ops: sign-extended 32-bit dividend).
REQ-021 Signed overflow (DIV/REM of INT_MIN by -1, including the 32-bit forms) SHALL complete in one BUSY cycle with quotient = the dividend and remainder = 0.
REQ-022 In DONE, result SHALL be held stable.
REQ-023 DONE SHALL return to IDLE on the first cycle with stall=0; with stall=1 it SHALL remain in DONE without restarting.
REQ-024 flush=1 in any state SHALL force IDLE next cycle and discard the partial result; a flush coinciding with valid SHALL NOT start an operation.
REQ-025 A valid arriving on the cycle DONE returns to IDLE belongs to the next instruction only; it SHALL be accepted the following cycle.

Reset
REQ-026 On reset, the following SHALL apply asynchronously:
- state = IDLE;
- counter = 0;
- result = 0;
- all operand and accumulator registers = 0.
REQ-027 Deassertion of reset SHALL take effect on the next rising clk edge.
REQ-028 Reset mid-operation SHALL abandon the operation; no result SHALL be produced.

Structure
REQ-029 mdu_op_t and the state enum SHALL reside in the shared pipes package; the iteration constants 64 and 32 SHALL be package localparams.
REQ-030 The divider datapath SHALL be the sub-module mdu_div_iter, which performs one restoring step per enable.
REQ-031 Multiply and control logic SHALL reside in multicycle_alu.

Verification
REQ-032 MUL with a=3, b=-5 -> e_wait high for 65 cycles, then result=0xFFFFFFFFFFFFFFF1.
REQ-033 DIV with a=-7, b=2 -> result=-3 after 65 cycles; REM with the same operands -> result=-1.
REQ-034 DIVU with b=0, a=0x1234 -> result=all ones after 2 cycles; REMU with the same operands -> result=0x1234.
REQ-035 DIVW with a=0x80000000, b=-1 -> result=0xFFFFFFFF80000000 after 2 cycles.
REQ-036 MULW with a=0x7FFFFFFF, b=2 -> result=0xFFFFFFFFFFFFFFFE after 33 cycles.
REQ-037 Flush at iteration 10, then reset in BUSY, then stall=1 for 5 cycles in DONE; each SHALL produce its required response:
- flush -> IDLE with e_wait=0 next cycle;
- reset -> IDLE with result=0 immediately;
- stall -> result held stable and no restart.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// Shared types for the multi-cycle M-extension unit: op encoding, FSM states,
// iteration counts and a small op-decode helper.
package multicycle_alu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ITER_D = 64;
  localparam int unsigned ITER_W = 32;
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7,
    OP_MULW   = 4'd8,
    OP_DIVW   = 4'd9,
    OP_DIVUW  = 4'd10,
    OP_REMW   = 4'd11,
    OP_REMUW  = 4'd12
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic is_w;
    logic is_mul;
    logic is_rem;
    logic hi;
    logic sa_signed;
    logic sb_signed;
  } op_info_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic op_info_t decode(input mdu_op_t op);
    op_info_t d;
    d = '0;
    case (op)
      OP_MUL:    begin d.is_mul = 1'b1; d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_MULH:   begin d.is_mul = 1'b1; d.hi = 1'b1; d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_MULHSU: begin d.is_mul = 1'b1; d.hi = 1'b1; d.sa_signed = 1'b1; end
      OP_MULHU:  begin d.is_mul = 1'b1; d.hi = 1'b1; end
      OP_DIV:    begin d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_DIVU:   ;
      OP_REM:    begin d.is_rem = 1'b1; d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_REMU:   d.is_rem = 1'b1;
      OP_MULW:   begin d.is_w = 1'b1; d.is_mul = 1'b1; d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_DIVW:   begin d.is_w = 1'b1; d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_DIVUW:  d.is_w = 1'b1;
      OP_REMW:   begin d.is_w = 1'b1; d.is_rem = 1'b1; d.sa_signed = 1'b1; d.sb_signed = 1'b1; end
      OP_REMUW:  begin d.is_w = 1'b1; d.is_rem = 1'b1; end
      default:   ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider over unsigned magnitudes; one quotient bit per enable.
// rem_c/quo_c expose the post-step values so the final step can be consumed directly.
module mdu_div_iter
  import multicycle_alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_c,
  output logic [XLEN-1:0] quo_c
);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   partial, diff;

  // Shift in the next dividend bit and keep the difference only if it did not borrow.
  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    diff    = partial - {1'b0, dvs_q};
    rem_c   = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    quo_c   = {quo_q[XLEN-2:0], ~diff[XLEN]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (en) begin
      rem_q <= rem_c;
      quo_q <= quo_c;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle multiply/divide unit for the E stage: shift-add multiply,
// restoring divide via mdu_div_iter, and the IDLE/BUSY/DONE handshake.
module multicycle_alu
  import multicycle_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        stall,
  input  logic        flush,
  output logic        e_wait,
  output logic [63:0] result
);

  state_t          state, state_nxt;
  op_info_t        info_d;
  logic            start, step, finish;
  logic [XLEN-1:0] ea, eb, mag_a, mag_b, special_val, dividend;
  logic            sa, sb, neg_d, div_zero, ovf, special_d;

  logic             w_q, mul_q, is_rem_q, hi_q, neg_q, special_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     mcand_q, prod_q, prod_nxt, prod_s;
  logic [XLEN-1:0]  mplier_q;
  logic [XLEN-1:0]  rem_c, quo_c, div_mag, div_s, mul_val, raw, final_val;

  // Operand preparation: extend, take magnitudes, detect the short-circuit divide cases.
  always_comb begin
    info_d = decode(mdu_op_t'(op));
    if (info_d.is_w) begin
      ea = info_d.sa_signed ? sext32(a[31:0]) : {32'b0, a[31:0]};
      eb = info_d.sb_signed ? sext32(b[31:0]) : {32'b0, b[31:0]};
    end else begin
      ea = a;
      eb = b;
    end
    sa       = info_d.sa_signed & ea[XLEN-1];
    sb       = info_d.sb_signed & eb[XLEN-1];
    mag_a    = sa ? XLEN'(-ea) : ea;
    mag_b    = sb ? XLEN'(-eb) : eb;
    neg_d    = info_d.is_rem ? sa : (sa ^ sb);
    dividend = info_d.is_w ? {mag_a[31:0], 32'b0} : mag_a;
    div_zero = (eb == '0);
    ovf      = info_d.sa_signed && info_d.sb_signed && (eb == '1) &&
               (info_d.is_w ? (ea == 64'hFFFF_FFFF_8000_0000) : (ea == 64'h8000_0000_0000_0000));
    special_d = !info_d.is_mul && (div_zero || ovf);
    if (div_zero)
      special_val = info_d.is_rem ? (info_d.is_w ? sext32(a[31:0]) : a) : '1;
    else
      special_val = info_d.is_rem ? '0 : ea;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    e_wait    = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        e_wait = valid;
        if (valid && !flush) begin
          start     = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        e_wait = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (special_q) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || !stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  mdu_div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .en       (step && !mul_q),
    .dividend (dividend),
    .divisor  (mag_b),
    .rem_c    (rem_c),
    .quo_c    (quo_c)
  );

  // Final-step result: the last partial product / restoring step feeds straight into sign fix-up.
  always_comb begin
    prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : 128'd0);
    prod_s    = neg_q ? 128'(-prod_nxt) : prod_nxt;
    mul_val   = hi_q ? prod_s[127:64] : prod_s[63:0];
    div_mag   = is_rem_q ? rem_c : quo_c;
    div_s     = neg_q ? XLEN'(-div_mag) : div_mag;
    raw       = mul_q ? mul_val : div_s;
    final_val = w_q ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q       <= 1'b0;
      mul_q     <= 1'b0;
      is_rem_q  <= 1'b0;
      hi_q      <= 1'b0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      result    <= '0;
    end else begin
      if (start) begin
        w_q       <= info_d.is_w;
        mul_q     <= info_d.is_mul;
        is_rem_q  <= info_d.is_rem;
        hi_q      <= info_d.hi;
        neg_q     <= neg_d;
        special_q <= special_d;
        cnt_q     <= info_d.is_w ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
        mcand_q   <= {64'b0, mag_a};
        mplier_q  <= mag_b;
        // Short-circuit results park in the low product half until the single BUSY cycle ends.
        prod_q    <= special_d ? {64'b0, special_val} : 128'd0;
      end else if (step) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (mul_q) begin
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
      end
      if (finish) result <= special_q ? prod_q[63:0] : final_val;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: latency, results, flush, reset and stall behaviour.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [3:0]  op;
  logic [63:0] a, b;
  logic        stall;
  logic        flush;
  logic        e_wait;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;

  multicycle_alu dut (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .op     (op),
    .a      (a),
    .b      (b),
    .stall  (stall),
    .flush  (flush),
    .e_wait (e_wait),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue an op at a negedge, count e_wait-high cycles, check result, then retire.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input int exp_cycles, input logic [63:0] exp_res);
    int cyc;
    valid = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    #1 check({tag, "_issue_wait"}, 64'(e_wait), 64'd1);
    cyc = 1;
    @(negedge clk);
    while (e_wait === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cycles));
    check({tag, "_result"}, result, exp_res);
    valid = 1'b0;
    @(negedge clk);
    #1 check({tag, "_idle_wait"}, 64'(e_wait), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    op    = OP_MUL;
    a     = '0;
    b     = '0;
    stall = 1'b0;
    flush = 1'b0;
    #1;
    check("reset_result", result, 64'd0);
    check("reset_wait", 64'(e_wait), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul",    OP_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 65, 64'hFFFF_FFFF_FFFF_FFF1);

    // Flush at iteration 10: partial work discarded, previous result kept.
    valid = 1'b1; op = OP_DIV; a = 64'd100; b = 64'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    #1;
    check("flush_busy_wait", 64'(e_wait), 64'd0);
    check("flush_busy_result", result, 64'hFFFF_FFFF_FFFF_FFF1);
    @(negedge clk);
    #1 check("flush_idle_still", 64'(e_wait), 64'd0);

    // Flush coinciding with valid must not start an op.
    valid = 1'b1; flush = 1'b1; op = OP_DIVU; a = 64'd9; b = 64'd0;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    #1 check("flush_valid_nostart", 64'(e_wait), 64'd0);
    @(negedge clk);
    #1 check("flush_valid_result", result, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op("div",    OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem",    OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu0",  OP_DIVU,   64'h1234, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu0",  OP_REMU,   64'h1234, 64'd0, 2, 64'h1234);
    run_op("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'hFFFF_FFFF_8000_0000);
    run_op("mulw",   OP_MULW,   64'h7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhu",  OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'd1);
    run_op("mulh",   OP_MULH,   64'h8000_0000_0000_0000, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulh_m1", OP_MULH,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'd0);
    run_op("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divuw",  OP_DIVUW,  64'hFFFF_FFFF_0000_0064, 64'd7, 33, 64'hE);
    run_op("remuw",  OP_REMUW,  64'h0000_0000_FFFF_FFF9, 64'h10, 33, 64'd9);
    run_op("rem_ovf", OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'd0);
    run_op("remw0",  OP_REMW,   64'h0000_0000_8000_0005, 64'd0, 2, 64'hFFFF_FFFF_8000_0005);
    run_op("div_neg", OP_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 65, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("remw",   OP_REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset while BUSY: result clears at once and nothing completes afterwards.
    valid = 1'b1; op = OP_MUL; a = 64'd9; b = 64'd9;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    valid = 1'b0;
    #1;
    check("rst_busy_result", result, 64'd0);
    check("rst_busy_wait", 64'(e_wait), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_after_result", result, 64'd0);
    check("rst_after_wait", 64'(e_wait), 64'd0);

    // Stall in DONE: result held, no restart even with valid high.
    stall = 1'b1;
    valid = 1'b1; op = OP_DIVU; a = 64'h1234; b = 64'd0;
    @(negedge clk);
    @(negedge clk);
    #1 check("stall_done_wait", 64'(e_wait), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_hold_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
      check("stall_hold_wait", 64'(e_wait), 64'd0);
    end

    // Release stall with the next instruction's valid already present: accepted one cycle later.
    stall = 1'b0;
    op = OP_MULW; a = 64'd5; b = 64'd6;
    @(negedge clk);
    #1 check("next_instr_held", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("next_mulw", OP_MULW, 64'd5, 64'd6, 33, 64'd30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
